// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
// Instruction-fetch stage feeding a single-cycle main decoder. Owns the PC,
// fetches each word over a req/ack handshake that tolerates wait states, holds
// the word in an instruction register and computes the next PC from the
// decoder's Branch/Jump outputs and the ALU Zero flag.
//
// Ports
//   clk         in   1   rising-edge clock
//   rst         in   1   asynchronous active-low reset
//   imem_req    out  1   fetch request, held until imem_ack
//   imem_addr   out  32  fetch address (= pc)
//   imem_ack    in   1   memory data valid on imem_rdata
//   imem_rdata  in   32  instruction word
//   stall       in   1   hold the current instruction in EXEC
//   Branch      in   1   decoder: instruction is BEQ
//   Jump        in   1   decoder: instruction is J
//   Zero        in   1   ALU zero flag
//   instr       out  32  instruction register
//   OP          out  6   instr[31:26]
//   instr_valid out  1   high only in EXEC; gates downstream commit
//   pc          out  32  address of the current instruction
//   fetch_err   out  1   sticky fetch timeout flag
// ---------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Zero,
    output logic [31:0] instr,
    output logic [5:0]  OP,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic        fetch_err
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_EXEC = 3'd3,
        ST_HALT = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [7:0]  wait_cnt_r, wait_cnt_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] instr_r, instr_s;
    logic        fetch_err_r, fetch_err_s;
    logic        imem_req_r, imem_req_s;
    logic        instr_valid_r, instr_valid_s;

    logic [31:0] pc4_s;
    logic [31:0] br_off_s;
    logic [31:0] next_pc_s;
    logic        ack_s;

    // Next-PC datapath: Jump has priority over a taken branch; all sums wrap.
    always_comb begin
        pc4_s    = pc_r + 32'd4;
        br_off_s = {{14{instr_r[15]}}, instr_r[15:0], 2'b00};
        if (Jump) begin
            next_pc_s = {pc4_s[31:28], instr_r[25:0], 2'b00};
        end else if (Branch && Zero) begin
            next_pc_s = pc4_s + br_off_s;
        end else begin
            next_pc_s = pc4_s;
        end
    end

    // Only an ack against an outstanding request is honoured.
    assign ack_s = imem_ack && imem_req_r;

    // Next-state and next-register logic for the fetch sequencer.
    always_comb begin
        state_s     = state_r;
        wait_cnt_s  = wait_cnt_r;
        pc_s        = pc_r;
        instr_s     = instr_r;
        fetch_err_s = fetch_err_r;
        case (state_r)
            ST_IDLE: begin
                state_s = ST_REQ;
            end
            ST_REQ: begin
                if (ack_s) begin
                    instr_s    = imem_rdata;
                    wait_cnt_s = 8'd0;
                    state_s    = ST_EXEC;
                end else begin
                    wait_cnt_s = 8'd1;
                    state_s    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // An ack arriving on the timeout cycle still wins.
                if (ack_s) begin
                    instr_s    = imem_rdata;
                    wait_cnt_s = 8'd0;
                    state_s    = ST_EXEC;
                end else if (wait_cnt_r == TIMEOUT_CNT) begin
                    fetch_err_s = 1'b1;
                    state_s     = ST_HALT;
                end else begin
                    wait_cnt_s = wait_cnt_r + 8'd1;
                end
            end
            ST_EXEC: begin
                if (stall) begin
                    state_s = ST_EXEC;
                end else begin
                    pc_s    = next_pc_s;
                    state_s = ST_REQ;
                end
            end
            ST_HALT: begin
                state_s = ST_HALT;
            end
            default: begin
                // Unreachable encodings recover through a clean refetch.
                state_s = ST_IDLE;
            end
        endcase
    end

    // Handshake and valid outputs are registered from the next state.
    always_comb begin
        imem_req_s    = (state_s == ST_REQ) || (state_s == ST_WAIT);
        instr_valid_s = (state_s == ST_EXEC);
    end

    // State and output registers; reset drops imem_req without a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            wait_cnt_r    <= 8'd0;
            pc_r          <= PC_RESET;
            instr_r       <= 32'd0;
            fetch_err_r   <= 1'b0;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            wait_cnt_r    <= wait_cnt_s;
            pc_r          <= pc_s;
            instr_r       <= instr_s;
            fetch_err_r   <= fetch_err_s;
            imem_req_r    <= imem_req_s;
            instr_valid_r <= instr_valid_s;
        end
    end

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign OP          = instr_r[31:26];
    assign instr_valid = instr_valid_r;
    assign pc          = pc_r;
    assign fetch_err   = fetch_err_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed testbench for fetch_pc_unit. A small memory responder acks after a
// programmable number of request cycles; a second instance with a high reset
// PC exercises jumps that keep the upper PC nibble.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req, imem_req_hi;
    logic [31:0] imem_addr, imem_addr_hi;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        Branch = 1'b0;
    logic        Jump = 1'b0;
    logic        Zero = 1'b0;
    logic [31:0] instr, instr_hi;
    logic [5:0]  OP, OP_hi;
    logic        instr_valid, instr_valid_hi;
    logic [31:0] pc, pc_hi;
    logic        fetch_err, fetch_err_hi;

    logic        mem_en = 1'b1;
    logic        ack_force = 1'b0;
    int          mem_wait = 0;
    int          req_cnt = 0;
    logic [31:0] mem_word = 32'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory responder: counts cycles the main DUT has held imem_req.
    always @(posedge clk or negedge rst) begin
        if (!rst) req_cnt <= 0;
        else if (imem_req) req_cnt <= req_cnt + 1;
        else req_cnt <= 0;
    end

    assign imem_ack   = ack_force | (mem_en & imem_req & (req_cnt >= mem_wait));
    assign imem_rdata = mem_word;

    fetch_pc_unit #(.PC_RESET(32'h0000_0000), .TIMEOUT(15)) u_dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .Branch(Branch), .Jump(Jump), .Zero(Zero), .instr(instr), .OP(OP),
        .instr_valid(instr_valid), .pc(pc), .fetch_err(fetch_err)
    );

    fetch_pc_unit #(.PC_RESET(32'h4000_0000), .TIMEOUT(15)) u_dut_hi (
        .clk(clk), .rst(rst), .imem_req(imem_req_hi), .imem_addr(imem_addr_hi),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .Branch(Branch), .Jump(Jump), .Zero(Zero), .instr(instr_hi), .OP(OP_hi),
        .instr_valid(instr_valid_hi), .pc(pc_hi), .fetch_err(fetch_err_hi)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset and release; returns with the DUT in REQ.
    task automatic do_reset();
        stall = 1'b0; Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
        ack_force = 1'b0; mem_en = 1'b1; mem_wait = 0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    // From REQ with zero-wait memory: fetch word, execute it, back in REQ.
    task automatic run_instr(input logic [31:0] w, input logic br, input logic jp, input logic z);
        mem_word = w; Branch = br; Jump = jp; Zero = z;
        step();
        step();
        Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (pc !== 32'h0 || instr !== 32'h0 || imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state pc=%h instr=%h req=%b valid=%b err=%b required 0", pc, instr, imem_req, instr_valid, fetch_err);
        end
        checks++;
        if (pc_hi !== 32'h4000_0000) begin
            errors++;
            $display("FAIL reset_pc_hi got %h required 40000000", pc_hi);
        end
    endtask

    task automatic test_sequential();
        mem_word = 32'h8C22_0004;
        rst = 1'b1;
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL seq_req0 req=%b addr=%h valid=%b required 1/0/0", imem_req, imem_addr, instr_valid);
        end
        step();
        checks++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== 32'h8C22_0004 || OP !== 6'h23) begin
            errors++;
            $display("FAIL seq_exec0 valid=%b req=%b instr=%h op=%h required 1/0/8c220004/23", instr_valid, imem_req, instr, OP);
        end
        mem_word = 32'h0022_1820;
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL seq_req1 req=%b addr=%h valid=%b required 1/4/0", imem_req, imem_addr, instr_valid);
        end
        step();
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h0022_1820 || OP !== 6'h00) begin
            errors++;
            $display("FAIL seq_exec1 valid=%b instr=%h op=%h required 1/00221820/00", instr_valid, instr, OP);
        end
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL seq_req2 req=%b addr=%h required 1/8", imem_req, imem_addr);
        end
    endtask

    task automatic test_branch();
        do_reset();
        run_instr(32'h1000_0003, 1'b1, 1'b0, 1'b1);
        checks++;
        if (pc !== 32'h10) begin errors++; $display("FAIL beq_to_10 pc=%h required 00000010", pc); end
        run_instr(32'h1000_0003, 1'b1, 1'b0, 1'b1);
        checks++;
        if (pc !== 32'h20) begin errors++; $display("FAIL beq_taken pc=%h required 00000020", pc); end
        do_reset();
        run_instr(32'h1000_0003, 1'b1, 1'b0, 1'b1);
        run_instr(32'h1000_0003, 1'b1, 1'b0, 1'b0);
        checks++;
        if (pc !== 32'h14) begin errors++; $display("FAIL beq_not_taken pc=%h required 00000014", pc); end
        do_reset();
        run_instr(32'h1000_000F, 1'b1, 1'b0, 1'b1);
        checks++;
        if (pc !== 32'h40) begin errors++; $display("FAIL beq_to_40 pc=%h required 00000040", pc); end
        run_instr(32'h1000_FFFE, 1'b1, 1'b0, 1'b1);
        checks++;
        if (pc !== 32'h3C) begin errors++; $display("FAIL beq_negative pc=%h required 0000003c", pc); end
    endtask

    task automatic test_jump();
        do_reset();
        run_instr(32'h0800_0100, 1'b0, 1'b1, 1'b0);
        checks++;
        if (pc !== 32'h400) begin errors++; $display("FAIL jump_low pc=%h required 00000400", pc); end
        checks++;
        if (pc_hi !== 32'h4000_0400) begin errors++; $display("FAIL jump_high pc=%h required 40000400", pc_hi); end
        do_reset();
        run_instr(32'h0800_0100, 1'b1, 1'b1, 1'b1);
        checks++;
        if (pc !== 32'h400) begin errors++; $display("FAIL jump_priority pc=%h required 00000400", pc); end
    endtask

    task automatic test_wait_stall();
        do_reset();
        mem_wait = 3;
        mem_word = 32'h2001_0005;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait_req cycle=%0d req=%b addr=%h valid=%b required 1/0/0", i, imem_req, imem_addr, instr_valid);
            end
            step();
        end
        mem_wait = 0;
        checks++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== 32'h2001_0005) begin
            errors++;
            $display("FAIL wait_exec valid=%b req=%b instr=%h required 1/0/20010005", instr_valid, imem_req, instr);
        end
        stall = 1'b1; Jump = 1'b1;
        ack_force = 1'b1; mem_word = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (instr_valid !== 1'b1 || pc !== 32'h0 || instr !== 32'h2001_0005 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cycle=%0d valid=%b pc=%h instr=%h req=%b required 1/0/20010005/0", i, instr_valid, pc, instr, imem_req);
            end
        end
        ack_force = 1'b0; stall = 1'b0; Jump = 1'b0;
        step();
        checks++;
        if (instr_valid !== 1'b0 || pc !== 32'h4 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL stall_release valid=%b pc=%h req=%b required 0/4/1", instr_valid, pc, imem_req);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_en = 1'b0;
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early err=%b req=%b required 0/1", fetch_err, imem_req);
        end
        step();
        checks++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_halt err=%b req=%b valid=%b required 1/0/0", fetch_err, imem_req, instr_valid);
        end
        ack_force = 1'b1; mem_word = 32'hCAFE_F00D;
        step();
        step();
        ack_force = 1'b0;
        checks++;
        if (instr !== 32'h0 || pc !== 32'h0 || fetch_err !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_ignores_ack instr=%h pc=%h err=%b req=%b required 0/0/1/0", instr, pc, fetch_err, imem_req);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (fetch_err !== 1'b0 || pc !== 32'h0) begin
            errors++;
            $display("FAIL timeout_reset err=%b pc=%h required 0/0", fetch_err, pc);
        end
        do_reset();
    endtask

    task automatic test_async_reset_and_wrap();
        do_reset();
        mem_en = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset req=%b valid=%b pc=%h err=%b required 0/0/0/0", imem_req, instr_valid, pc, fetch_err);
        end
        do_reset();
        run_instr(32'h1000_3FFE, 1'b1, 1'b0, 1'b1);
        checks++;
        if (pc !== 32'h0000_FFFC) begin errors++; $display("FAIL pc_to_fffc pc=%h required 0000fffc", pc); end
        run_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pc !== 32'h0001_0000) begin errors++; $display("FAIL pc_carry pc=%h required 00010000", pc); end
        do_reset();
        run_instr(32'h1000_FFFE, 1'b1, 1'b0, 1'b1);
        checks++;
        if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL pc_to_top pc=%h required fffffffc", pc); end
        run_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pc !== 32'h0) begin errors++; $display("FAIL pc_wrap pc=%h required 00000000", pc); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_wait_stall();
        test_timeout();
        test_async_reset_and_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
